multdiv_controller: RTL and testbench
=====================================

Name: multdiv_controller

Overview:
- Execute-stage sequencer for the shared multi-cycle multiplier/divider.
- Detects a mul or div R-type instruction in DX, issues a one-cycle start pulse, and holds operands stable.
- Stalls PC/FD/DX and bubbles XM until the unit reports ready or a timeout expires.
- Returns result and exception status for one cycle so the XM latches capture it.

Parameters:
- TIMEOUT_CYCLES, 40: BUSY cycles allowed before forced completion.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- dx_insn  in  32  instruction currently in DX
- op_a  in  32  bypassed rs operand
- op_b  in  32  bypassed rt operand
- ctrl_mult  out  1  start-multiply pulse to multdiv unit
- ctrl_div  out  1  start-divide pulse to multdiv unit
- md_a  out  32  operand A to multdiv unit
- md_b  out  32  operand B to multdiv unit
- md_result  in  32  multdiv result
- md_exception  in  1  overflow / divide-by-zero from unit
- md_ready  in  1  result valid, single-cycle pulse
- stall  out  1  freeze PC, FD, DX; insert nop into XM
- result  out  32  captured result
- result_valid  out  1  result/exception valid this cycle
- exception  out  1  operation failed (unit exception or timeout)
- exc_code  out  32  rstatus value: 4 = mult, 5 = div, 0 = none
- timeout  out  1  completion was forced by the counter

Behaviour:
- Decode:
  - is_mult = (dx_insn[31:27] == 0) and (dx_insn[6:2] == 6).
  - is_div = (dx_insn[31:27] == 0) and (dx_insn[6:2] == 7).
- States: IDLE, BUSY, DONE. On reset: state IDLE, count 0, held regs 0, all outputs 0.
- IDLE:
  - md_a/md_b pass op_a/op_b combinationally.
  - If is_mult or is_div: ctrl_mult or ctrl_div = 1 this cycle, stall = 1, op_a/op_b and the op kind are captured into held regs, next state BUSY, count <= 0.
  - Otherwise all outputs stay 0.
  - md_ready in IDLE is ignored.
- BUSY:
  - stall = 1; ctrl_* = 0; md_a/md_b drive held regs; count increments each cycle.
  - On md_ready = 1: capture md_result and md_exception, then go to DONE.
  - If count == TIMEOUT_CYCLES-1 with no md_ready: capture result 0, exception 1, timeout 1, then go to DONE.
  - If md_ready and timeout coincide, md_ready wins (timeout = 0).
- DONE:
  - stall = 0; result_valid = 1 for exactly one cycle.
  - result, exception and timeout come from captured regs; exc_code = exception ? (op was mult ? 4 : 5) : 0.
  - Next state IDLE; no start is permitted from DONE, so the retiring instruction is never reissued.
- Latency: issue cycle + N BUSY cycles + 1 DONE cycle. Stall is high for N+1 cycles.
- Back-to-back mul/div:
  - Second instruction reaches DX the cycle after DONE and issues from IDLE.
  - Minimum 1-cycle gap between start pulses.
- Reset low mid-operation: immediate return to IDLE with outputs 0. A stale md_ready afterwards is ignored.
- result/exception/exc_code read 0 whenever result_valid = 0.
- ctrl_mult and ctrl_div are never high together.

Decomposition:
- Shared package contents:
  - opcode and ALU-op constants: R-type 0, MUL 6, DIV 7
  - rstatus exception codes 4 and 5
  - state encoding for IDLE/BUSY/DONE
- Natural sub-module: md_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired flag at TIMEOUT_CYCLES-1.
  - Shares the asynchronous active-low reset.

Test Plan:
- mul, op_a = 7, op_b = 6, md_ready pulsed after 3 BUSY cycles with result 42:
  - ctrl_mult high 1 cycle; stall high 4 cycles.
  - Next cycle: result_valid = 1, result = 42, exc_code = 0.
- div, op_b = 0, unit returns md_exception = 1:
  - ctrl_div pulse.
  - result_valid cycle: exception = 1, exc_code = 5, result = 0.
- mul with md_ready never asserted:
  - stall held exactly TIMEOUT_CYCLES+1 cycles.
  - Then: result_valid = 1, timeout = 1, exception = 1, exc_code = 4.
- Two consecutive mul instructions:
  - Second ctrl_mult is exactly 1 cycle after the first result_valid.
  - md_a/md_b held at first operands throughout the first BUSY phase even while op_a changes.
- reset driven low during BUSY, then md_ready pulsed after release:
  - Outputs 0 immediately.
  - No result_valid, state stays IDLE.
- add instruction (ALU op 0) in DX:
  - stall, ctrl_mult, ctrl_div and result_valid all stay 0.

Source files
------------

// File: rtl/multdiv_controller_pkg.sv
// Shared constants, state encoding and instruction decode for the execute-stage
// multiply/divide sequencer.
package multdiv_controller_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'd0;
  localparam logic [4:0] ALU_MUL   = 5'd6;
  localparam logic [4:0] ALU_DIV   = 5'd7;

  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;
  localparam logic [31:0] EXC_NONE = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  typedef struct packed {
    logic is_mult;
    logic is_div;
  } md_decode_t;

  function automatic md_decode_t decode_fields(input logic [4:0] opcode,
                                               input logic [4:0] alu_op);
    md_decode_t dec;
    dec.is_mult = (opcode == OPC_RTYPE) && (alu_op == ALU_MUL);
    dec.is_div  = (opcode == OPC_RTYPE) && (alu_op == ALU_DIV);
    return dec;
  endfunction

  function automatic logic [31:0] exc_code_for(input logic exc, input logic was_mult);
    if (!exc) begin
      return EXC_NONE;
    end
    return was_mult ? EXC_MULT : EXC_DIV;
  endfunction

endpackage

// File: rtl/multdiv_controller_if.sv
// Bundle between the pipeline/multdiv unit side (master) and the sequencer (slave).
interface multdiv_controller_if;
  logic [31:0] dx_insn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        exception;
  logic [31:0] exc_code;
  logic        timeout;

  modport master (
    output dx_insn, op_a, op_b, md_result, md_exception, md_ready,
    input  ctrl_mult, ctrl_div, md_a, md_b, stall,
    input  result, result_valid, exception, exc_code, timeout
  );

  modport slave (
    input  dx_insn, op_a, op_b, md_result, md_exception, md_ready,
    output ctrl_mult, ctrl_div, md_a, md_b, stall,
    output result, result_valid, exception, exc_code, timeout
  );
endinterface

// File: rtl/multdiv_controller_md_timeout_counter.sv
// Counts BUSY cycles for the multdiv sequencer and flags when the allowance is used up.
module md_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic i_clock,
  input  logic i_reset,   // active-low, asynchronous
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Raised during the last permitted BUSY cycle, so completion lands on the next edge.
  assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer: issues a start pulse to the shared multiplier/divider,
// stalls the front of the pipe while it runs and presents the result for one cycle.
module multdiv_controller
  import multdiv_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,   // active-low, asynchronous
  multdiv_controller_if.slave  io_bus
);

  md_state_t   r_state;
  md_state_t   w_state_next;
  md_decode_t  w_dec;

  logic [31:0] r_held_a;
  logic [31:0] r_held_b;
  logic        r_op_mult;
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_timeout;

  logic        w_issue;
  logic        w_cap_ready;
  logic        w_cap_timeout;
  logic        w_cnt_en;
  logic        w_expired;

  logic        w_ctrl_mult;
  logic        w_ctrl_div;
  logic [31:0] w_md_a;
  logic [31:0] w_md_b;
  logic        w_stall;
  logic [31:0] w_result;
  logic        w_result_valid;
  logic        w_exception;
  logic [31:0] w_exc_code;
  logic        w_timeout;

  assign w_dec = decode_fields(io_bus.dx_insn[31:27], io_bus.dx_insn[6:2]);

  md_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_issue),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_issue        = 1'b0;
    w_cap_ready    = 1'b0;
    w_cap_timeout  = 1'b0;
    w_cnt_en       = 1'b0;
    w_ctrl_mult    = 1'b0;
    w_ctrl_div     = 1'b0;
    w_md_a         = io_bus.op_a;
    w_md_b         = io_bus.op_b;
    w_stall        = 1'b0;
    w_result       = '0;
    w_result_valid = 1'b0;
    w_exception    = 1'b0;
    w_exc_code     = '0;
    w_timeout      = 1'b0;

    // Reset is asynchronous, so the combinational outputs must also drop at once.
    if (!i_reset) begin
      w_state_next = ST_IDLE;
      w_md_a       = '0;
      w_md_b       = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_dec.is_mult || w_dec.is_div) begin
            w_issue      = 1'b1;
            w_ctrl_mult  = w_dec.is_mult;
            w_ctrl_div   = w_dec.is_div && !w_dec.is_mult;
            w_stall      = 1'b1;
            w_state_next = ST_BUSY;
          end
        end

        ST_BUSY: begin
          w_stall  = 1'b1;
          w_cnt_en = 1'b1;
          w_md_a   = r_held_a;
          w_md_b   = r_held_b;
          // A real result always beats a coincident timeout.
          if (io_bus.md_ready) begin
            w_cap_ready  = 1'b1;
            w_state_next = ST_DONE;
          end else if (w_expired) begin
            w_cap_timeout = 1'b1;
            w_state_next  = ST_DONE;
          end
        end

        ST_DONE: begin
          w_md_a         = r_held_a;
          w_md_b         = r_held_b;
          w_result_valid = 1'b1;
          w_result       = r_result;
          w_exception    = r_exception;
          w_exc_code     = exc_code_for(r_exception, r_op_mult);
          w_timeout      = r_timeout;
          w_state_next   = ST_IDLE;
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_held_a    <= '0;
      r_held_b    <= '0;
      r_op_mult   <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_held_a  <= io_bus.op_a;
        r_held_b  <= io_bus.op_b;
        r_op_mult <= w_dec.is_mult;
      end
      if (w_cap_ready) begin
        r_result    <= io_bus.md_result;
        r_exception <= io_bus.md_exception;
        r_timeout   <= 1'b0;
      end else if (w_cap_timeout) begin
        r_result    <= '0;
        r_exception <= 1'b1;
        r_timeout   <= 1'b1;
      end
    end
  end

  assign io_bus.ctrl_mult    = w_ctrl_mult;
  assign io_bus.ctrl_div     = w_ctrl_div;
  assign io_bus.md_a         = w_md_a;
  assign io_bus.md_b         = w_md_b;
  assign io_bus.stall        = w_stall;
  assign io_bus.result       = w_result;
  assign io_bus.result_valid = w_result_valid;
  assign io_bus.exception    = w_exception;
  assign io_bus.exc_code     = w_exc_code;
  assign io_bus.timeout      = w_timeout;

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller against a transaction-level model.
module tb_multdiv_controller;

  localparam int TO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_controller_if bus();

  multdiv_controller #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (6)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations of one transaction
  int          obs_stall, obs_mult, obs_div, obs_valid_idx, obs_valid_cyc, obs_start_cyc;
  logic [31:0] obs_result, obs_code;
  logic        obs_exc, obs_to;
  bit          obs_hold_bad, obs_both, obs_leak;

  function automatic logic [31:0] mk_insn(input logic [4:0] opc, input logic [4:0] alu);
    logic [19:0] mid;
    logic [1:0]  lo;
    mid = 20'($urandom);
    lo  = 2'($urandom);
    return {opc, mid, alu, lo};
  endfunction

  // Reference: BUSY length is the ready cycle if it lands within the allowance, else the allowance.
  function automatic int exp_busy(input int ready_at);
    return (ready_at >= 1 && ready_at <= TO) ? ready_at : TO;
  endfunction

  function automatic logic [31:0] exp_code(input logic exc, input bit is_mul);
    if (!exc) return 32'd0;
    return is_mul ? 32'd4 : 32'd5;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.dx_insn   = mk_insn(5'd0, 5'd0);
      bus.md_ready  = 1'b0;
    end
  endtask

  // Drives one instruction from DX, asserts md_ready in BUSY cycle ready_at (0 = never).
  task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int ready_at, input logic [31:0] res, input logic exc,
                        input bit wiggle);
    obs_stall = 0; obs_mult = 0; obs_div = 0; obs_valid_idx = -1; obs_valid_cyc = -1;
    obs_start_cyc = -1; obs_result = '0; obs_code = '0; obs_exc = 0; obs_to = 0;
    obs_hold_bad = 0; obs_both = 0; obs_leak = 0;
    for (int c = 0; c < TO + 10; c++) begin
      @(posedge clk); #1;
      bus.dx_insn      = insn;
      bus.op_b         = b;
      bus.op_a         = (wiggle && c > 0) ? 32'($urandom) : a;
      bus.md_ready     = (c > 0 && c == ready_at);
      bus.md_result    = (c == ready_at) ? res : 32'($urandom);
      bus.md_exception = (c == ready_at) ? exc : 1'($urandom);
      @(negedge clk);
      if (bus.stall) obs_stall++;
      if (bus.ctrl_mult) obs_mult++;
      if (bus.ctrl_div) obs_div++;
      if ((bus.ctrl_mult || bus.ctrl_div) && obs_start_cyc < 0) obs_start_cyc = cyc;
      if (bus.ctrl_mult && bus.ctrl_div) obs_both = 1;
      if (bus.stall && (bus.md_a !== a || bus.md_b !== b)) obs_hold_bad = 1;
      if (!bus.result_valid && (bus.result !== 0 || bus.exception !== 0 ||
                                bus.exc_code !== 0 || bus.timeout !== 0)) obs_leak = 1;
      if (bus.result_valid) begin
        obs_valid_idx = c;
        obs_valid_cyc = cyc;
        obs_result    = bus.result;
        obs_exc       = bus.exception;
        obs_code      = bus.exc_code;
        obs_to        = bus.timeout;
        break;
      end
    end
    bus.md_ready = 1'b0;
    $display("txn insn=%08h a=%0d b=%0d ready_at=%0d -> stall=%0d valid_idx=%0d result=%0d exc=%0b code=%0d to=%0b",
             insn, a, b, ready_at, obs_stall, obs_valid_idx, obs_result, obs_exc, obs_code, obs_to);
  endtask

  task automatic test_reset();
    bit bad = 0;
    bus.dx_insn = mk_insn(5'd0, 5'd6); bus.op_a = 32'd3; bus.op_b = 32'd4;
    bus.md_result = '0; bus.md_exception = 1'b0; bus.md_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.stall !== 0 || bus.ctrl_mult !== 0 || bus.ctrl_div !== 0 || bus.result_valid !== 0 ||
          bus.result !== 0 || bus.exc_code !== 0 || bus.md_a !== 0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%0b ctrl_mult=%0b valid=%0b required all 0",
               bus.stall, bus.ctrl_mult, bus.result_valid);
    end
    bus.dx_insn = mk_insn(5'd0, 5'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_mul_basic();
    run_op(mk_insn(5'd0, 5'd6), 32'd7, 32'd6, 3, 32'd42, 1'b0, 0);
    idle(2);
    checks++; if (obs_mult != 1 || obs_div != 0) begin errors++;
      $display("FAIL mul_pulse: got mult=%0d div=%0d required 1/0", obs_mult, obs_div); end
    checks++; if (obs_stall != 4) begin errors++;
      $display("FAIL mul_stall: got %0d required 4", obs_stall); end
    checks++; if (obs_valid_idx != 4) begin errors++;
      $display("FAIL mul_latency: got %0d required 4", obs_valid_idx); end
    checks++; if (obs_result !== 32'd42 || obs_code !== 32'd0 || obs_exc !== 1'b0 || obs_to !== 1'b0) begin errors++;
      $display("FAIL mul_result: got result=%0d code=%0d exc=%0b to=%0b required 42/0/0/0",
               obs_result, obs_code, obs_exc, obs_to); end
    checks++; if (obs_hold_bad || obs_leak || obs_both) begin errors++;
      $display("FAIL mul_side: got hold_bad=%0b leak=%0b both=%0b required 0", obs_hold_bad, obs_leak, obs_both); end
  endtask

  task automatic test_div_exception();
    int ra = int'($urandom_range(1, 6));
    run_op(mk_insn(5'd0, 5'd7), 32'($urandom), 32'd0, ra, 32'd0, 1'b1, 0);
    idle(2);
    checks++; if (obs_div != 1 || obs_mult != 0) begin errors++;
      $display("FAIL div_pulse: got div=%0d mult=%0d required 1/0", obs_div, obs_mult); end
    checks++; if (obs_stall != ra + 1) begin errors++;
      $display("FAIL div_stall: got %0d required %0d", obs_stall, ra + 1); end
    checks++; if (obs_exc !== 1'b1 || obs_code !== 32'd5 || obs_result !== 32'd0 || obs_to !== 1'b0) begin errors++;
      $display("FAIL div_exc: got exc=%0b code=%0d result=%0d to=%0b required 1/5/0/0",
               obs_exc, obs_code, obs_result, obs_to); end
  endtask

  task automatic test_timeout();
    run_op(mk_insn(5'd0, 5'd6), 32'($urandom), 32'($urandom), 0, 32'd0, 1'b0, 0);
    idle(2);
    checks++; if (obs_stall != TO + 1) begin errors++;
      $display("FAIL timeout_stall: got %0d required %0d", obs_stall, TO + 1); end
    checks++; if (obs_valid_idx != TO + 1) begin errors++;
      $display("FAIL timeout_latency: got %0d required %0d", obs_valid_idx, TO + 1); end
    checks++; if (obs_to !== 1'b1 || obs_exc !== 1'b1 || obs_code !== 32'd4 || obs_result !== 32'd0) begin errors++;
      $display("FAIL timeout_flags: got to=%0b exc=%0b code=%0d result=%0d required 1/1/4/0",
               obs_to, obs_exc, obs_code, obs_result); end
  endtask

  task automatic test_coincide();
    logic [31:0] r = 32'($urandom);
    run_op(mk_insn(5'd0, 5'd7), 32'd9, 32'd3, TO, r, 1'b0, 0);
    idle(2);
    checks++; if (obs_stall != TO + 1 || obs_to !== 1'b0 || obs_result !== r || obs_exc !== 1'b0) begin errors++;
      $display("FAIL ready_wins: got stall=%0d to=%0b result=%0d exc=%0b required %0d/0/%0d/0",
               obs_stall, obs_to, obs_result, obs_exc, TO + 1, r); end
  endtask

  task automatic test_back_to_back();
    int first_valid;
    bit hold_bad;
    run_op(mk_insn(5'd0, 5'd6), 32'd11, 32'd13, 5, 32'd143, 1'b0, 1);
    first_valid = obs_valid_cyc;
    hold_bad    = obs_hold_bad;
    run_op(mk_insn(5'd0, 5'd6), 32'd2, 32'd3, 2, 32'd6, 1'b0, 0);
    idle(2);
    checks++; if (hold_bad) begin errors++;
      $display("FAIL b2b_hold: got operands changed during BUSY required held 11/13"); end
    checks++; if (first_valid < 0 || obs_start_cyc != first_valid + 1) begin errors++;
      $display("FAIL b2b_gap: got second start cycle %0d required %0d", obs_start_cyc, first_valid + 1); end
    checks++; if (obs_result !== 32'd6 || obs_stall != 3) begin errors++;
      $display("FAIL b2b_second: got result=%0d stall=%0d required 6/3", obs_result, obs_stall); end
  endtask

  task automatic test_reset_mid_busy();
    bit bad = 0;
    run_op(mk_insn(5'd0, 5'd6), 32'd5, 32'd5, 0, 32'd0, 1'b0, 0) ;
    // run_op above times out; now issue again and cut it short with reset
    @(posedge clk); #1;
    bus.dx_insn = mk_insn(5'd0, 5'd6); bus.op_a = 32'd8; bus.op_b = 32'd9; bus.md_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 0 || bus.ctrl_mult !== 0 || bus.result_valid !== 0) begin
      errors++;
      $display("FAIL reset_immediate: got stall=%0b ctrl_mult=%0b valid=%0b required 0/0/0",
               bus.stall, bus.ctrl_mult, bus.result_valid);
    end
    @(posedge clk); #1;
    bus.dx_insn = mk_insn(5'd0, 5'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.md_ready = 1'b1; bus.md_result = 32'($urandom); bus.md_exception = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.result_valid !== 0 || bus.stall !== 0 || bus.exception !== 0) bad = 1;
      @(posedge clk); #1;
      bus.md_ready = 1'b0;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stale_ready: got valid/stall activity after reset required none");
    end
  endtask

  task automatic test_non_md();
    bit bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      // add, and a non-R-type opcode whose low field looks like mul/div
      bus.dx_insn  = (i % 2 == 0) ? mk_insn(5'd0, 5'd0) : mk_insn(5'(i + 1), (i % 4 == 1) ? 5'd6 : 5'd7);
      bus.md_ready = 1'($urandom);
      @(negedge clk);
      if (bus.stall !== 0 || bus.ctrl_mult !== 0 || bus.ctrl_div !== 0 || bus.result_valid !== 0) bad = 1;
    end
    bus.md_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL non_md: got stall=%0b mult=%0b div=%0b valid=%0b required all 0",
               bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.result_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      bit          is_mul = 1'($urandom);
      int          ra     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                                       : int'($urandom_range(1, 8));
      logic [31:0] a      = 32'($urandom);
      logic [31:0] b      = 32'($urandom);
      logic [31:0] r      = 32'($urandom);
      logic        e      = 1'($urandom);
      int          busy   = exp_busy(ra);
      bit          to     = !(ra >= 1 && ra <= TO);
      logic        ee     = to ? 1'b1 : e;
      logic [31:0] er     = to ? 32'd0 : r;
      run_op(mk_insn(5'd0, is_mul ? 5'd6 : 5'd7), a, b, ra, r, e, 1);
      if ($urandom_range(0, 1) == 0) idle(1);
      checks++;
      if (obs_stall != busy + 1 || obs_valid_idx != busy + 1) begin errors++;
        $display("FAIL rnd_timing[%0d]: got stall=%0d valid_idx=%0d required %0d/%0d",
                 n, obs_stall, obs_valid_idx, busy + 1, busy + 1); end
      checks++;
      if (obs_result !== er || obs_exc !== ee || obs_to !== to || obs_code !== exp_code(ee, is_mul)) begin errors++;
        $display("FAIL rnd_result[%0d]: got result=%0d exc=%0b to=%0b code=%0d required %0d/%0b/%0b/%0d",
                 n, obs_result, obs_exc, obs_to, obs_code, er, ee, to, exp_code(ee, is_mul)); end
      checks++;
      if (obs_mult != (is_mul ? 1 : 0) || obs_div != (is_mul ? 0 : 1) || obs_hold_bad || obs_leak || obs_both) begin errors++;
        $display("FAIL rnd_ctrl[%0d]: got mult=%0d div=%0d hold_bad=%0b leak=%0b both=%0b required %0d/%0d/0/0/0",
                 n, obs_mult, obs_div, obs_hold_bad, obs_leak, obs_both, is_mul ? 1 : 0, is_mul ? 0 : 1); end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_timeout();
    test_coincide();
    test_back_to_back();
    test_reset_mid_busy();
    test_non_md();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
